seq_detector_n: RTL

SEQ_DETECTOR_N -- requirements
Module: seq_detector_n

---
 rtl/seq_pkg.sv | 35 +++
 rtl/seg7_hex.sv | 38 +++
 rtl/seq_detector_n.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared constants for the serial pattern detector family.
//   PAT_LEN_MAX : largest supported pattern length (bits)
//   K_W         : width of the matched-prefix / fill counters (holds 0..PAT_LEN_MAX)
//   CNT_W       : width of the saturating match counter
//   CNT_MAX     : saturation value of the match counter
//   SEG_0..SEG_F: active-low 7-segment glyphs, bit order {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package seq_pkg;

  localparam int PAT_LEN_MAX = 8;
  localparam int K_W         = $clog2(PAT_LEN_MAX + 1);
  localparam int CNT_W       = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_hex.sv
// -----------------------------------------------------------------------------
// seg7_hex
// Hex digit to active-low 7-segment decoder (purely combinational).
// Ports:
//   digit : in  [3:0]  value 0..F
//   seg   : out [6:0]  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_hex
  import seq_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    unique case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/seq_detector_n.sv
// -----------------------------------------------------------------------------
// seq_detector_n
// Serial pattern detector for a loadable PAT_LEN-bit pattern. The state k is
// the length of the longest pattern prefix that equals a suffix of the bits
// received since the last restart; a match is flagged while k == PAT_LEN.
//
// Parameters:
//   PAT_LEN  : pattern length in bits, 2..8
//   PAT_INIT : pattern after reset; bit PAT_LEN-1 is the first bit expected
//   OVERLAP  : 1 = a new match may reuse bits of the previous one,
//              0 = detection restarts from scratch after each match
//
// Ports:
//   Clock     : in   system clock, rising edge
//   Resetn    : in   asynchronous active-low reset
//   w         : in   serial data bit, sampled when en = 1
//   en        : in   sample enable; en = 0 holds k, history, z and match_cnt
//   load      : in   capture pat_in and restart detection (wins over en)
//   pat_in    : in   [PAT_LEN-1:0] new pattern
//   clr       : in   synchronous clear of match_cnt (wins over a match)
//   z         : out  1 while a full match is held (registered, Moore)
//   match_cnt : out  [7:0] saturating number of matches
//   CurState  : out  [3:0] current matched-prefix length k
//   HEX0      : out  [6:0] active-low hex display of CurState
//               (present only when SEQ_DETECTOR_HEX_EN is defined)
//
// Configuration macro: SEQ_DETECTOR_HEX_EN
// -----------------------------------------------------------------------------
module seq_detector_n
  import seq_pkg::*;
#(
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PAT_INIT = PAT_LEN'(4'b1101),
  parameter bit                 OVERLAP  = 1'b1
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               w,
  input  logic               en,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
`ifdef SEQ_DETECTOR_HEX_EN
  output logic [6:0]         HEX0,
`endif
  output logic [3:0]         CurState
);

  localparam logic [K_W-1:0] K_FULL = K_W'(PAT_LEN);

  // Registered state
  logic [PAT_LEN-1:0] pat_q;    // active pattern
  logic [PAT_LEN-1:0] hist_q;   // received bits, bit 0 newest
  logic [K_W-1:0]     fill_q;   // number of valid bits in hist_q
  logic [K_W-1:0]     k_q;      // matched-prefix length
  logic [CNT_W-1:0]   cnt_q;    // saturating match counter

  // Next-state terms
  logic [PAT_LEN-1:0] hist_shift;
  logic [K_W-1:0]     fill_avail;
  logic [K_W-1:0]     fill_next;
  logic [K_W-1:0]     k_next;
  logic               match_next;
  logic               hit;

  // The oldest history bit is shifted out before it can take part in any
  // comparison (the window including the new w is only PAT_LEN bits wide).
  logic unused_hist_msb;
  assign unused_hist_msb = hist_q[PAT_LEN-1];

  // Window of the last PAT_LEN bits including the bit being sampled now.
  assign hist_shift = {hist_q[PAT_LEN-2:0], w};

  // Bits usable for this edge's comparison: the stored fill plus the new bit.
  // In non-overlapping mode fill_q is already 0 after a match, so only the
  // new bit can contribute on the following edge.
  assign fill_avail = (fill_q < K_FULL) ? fill_q + K_W'(1) : K_FULL;

  // Longest j <= fill_avail for which the last j window bits equal the first
  // j pattern bits. Ascending j, so the last hit wins and is the longest.
  always_comb begin
    k_next = '0;
    hit    = 1'b0;
    for (int j = 1; j <= PAT_LEN; j++) begin
      hit = (K_W'(j) <= fill_avail);
      for (int i = 0; i < j; i++) begin
        if (hist_shift[i] != pat_q[PAT_LEN-j+i]) begin
          hit = 1'b0;
        end
      end
      if (hit) begin
        k_next = K_W'(j);
      end
    end
  end

  assign match_next = (k_next == K_FULL);

  // Non-overlapping mode forgets the history on the match edge itself.
  always_comb begin
    fill_next = fill_avail;
    if (!OVERLAP && match_next) begin
      fill_next = '0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pat_q  <= PAT_INIT;
      hist_q <= '0;
      fill_q <= '0;
      k_q    <= '0;
    end else if (load) begin
      // A load restarts detection and discards w on this edge.
      pat_q  <= pat_in;
      hist_q <= '0;
      fill_q <= '0;
      k_q    <= '0;
    end else if (en) begin
      hist_q <= hist_shift;
      fill_q <= fill_next;
      k_q    <= k_next;
    end
  end

  // Counter: clr beats a simultaneous match; a load edge never counts.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !load && match_next && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign z         = (k_q == K_FULL);
  assign match_cnt = cnt_q;
  assign CurState  = 4'(k_q);

`ifdef SEQ_DETECTOR_HEX_EN
  seg7_hex u_seg7_hex (
    .digit (CurState),
    .seg   (HEX0)
  );
`endif

endmodule
